bomb_countdown_timer: RTL and testbench

Programmable seconds countdown for the bomb controller, generalising the fixed 50 MHz half-second/second tick generator. A prescaler derived from `CLK_HZ` produces half-second and second strobes, and a loadable seconds counter counts down to zero. The block supports start/pause control, a sticky expiry flag and a beep strobe for the sounder. It sits between the keypad/arming FSM, which drives load/start/pause, and the display and sounder logic, which consume `remaining`, `beep` and `expired`.

---
 rtl/bomb_timer_pkg.sv | 19 +
 rtl/bomb_register.sv | 32 +++
 rtl/bomb_countdown_timer.sv | 125 ++++++++++++
 tb/tb_bomb_countdown_timer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_timer_pkg.sv
// Shared types for the bomb countdown timer: FSM state encoding and the
// control codes understood by bomb_register.
package bomb_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_LOAD = 2'd1,
    REG_INCR = 2'd2,
    REG_DECR = 2'd3
  } reg_ctrl_t;

endpackage

// File: rtl/bomb_register.sv
// Generic W-bit register with load / increment / decrement / hold control,
// used for both the prescaler and the seconds counter.
module bomb_register
  import bomb_timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           async_nreset,
  input  reg_ctrl_t      i_ctrl,
  input  logic [W-1:0]   i_value,
  output logic [W-1:0]   o_value
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_value <= '0;
    end else begin
      case (i_ctrl)
        REG_LOAD: r_value <= i_value;
        REG_INCR: r_value <= r_value + W'(1);
        REG_DECR: r_value <= r_value - W'(1);
        default:  r_value <= r_value;
      endcase
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/bomb_countdown_timer.sv
// Seconds countdown with start/pause, sticky expiry and sounder strobe.
// Optional BOMB_TIMER_WARN_BEEP_EN: beep on every half second once remaining <= WARN_SECS.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | loaded or reset, waiting for start
// ST_RUN     | prescaler counting, seconds decrement on wrap
// ST_PAUSED  | counting frozen, prescaler holds its phase
// ST_EXPIRED | countdown reached zero, waits for load
module bomb_countdown_timer
  import bomb_timer_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PRESC_W   = 32,
  parameter int SEC_W     = 8,
  parameter int WARN_SECS = 10
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic             busy,
  output logic [SEC_W-1:0] remaining,
  output logic             half_second,
  output logic             second,
  output logic             expired,
  output logic             beep
);

  localparam logic [PRESC_W-1:0] LP_PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [PRESC_W-1:0] LP_PRESC_HALF = PRESC_W'(CLK_HZ / 2 - 1);

  timer_state_t       r_state;
  timer_state_t       w_next_state;
  logic               r_busy;
  logic               r_expired;
  logic [PRESC_W-1:0] w_presc;
  logic [SEC_W-1:0]   w_secs;
  reg_ctrl_t          w_presc_ctrl;
  reg_ctrl_t          w_secs_ctrl;
  logic               w_run;
  logic               w_half;
  logic               w_second;

  assign w_run    = (r_state == ST_RUN);
  assign w_half   = w_run && ((w_presc == LP_PRESC_HALF) || (w_presc == LP_PRESC_LAST));
  assign w_second = w_run && (w_presc == LP_PRESC_LAST);

  // Reaching zero on a second strobe expires even if pause arrives in the same cycle.
  always_comb begin
    w_next_state = r_state;
    if (load) begin
      w_next_state = ST_IDLE;
    end else if (start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))) begin
      w_next_state = (w_secs != '0) ? ST_RUN : ST_EXPIRED;
    end else if (r_state == ST_RUN) begin
      if (w_second && (w_secs == SEC_W'(1))) begin
        w_next_state = ST_EXPIRED;
      end else if (pause) begin
        w_next_state = ST_PAUSED;
      end
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_busy    <= (w_next_state == ST_RUN);
      r_expired <= (w_next_state == ST_EXPIRED);
    end
  end

  always_comb begin
    w_presc_ctrl = REG_NONE;
    if (load) begin
      w_presc_ctrl = REG_LOAD;
    end else if (w_run) begin
      w_presc_ctrl = (w_presc == LP_PRESC_LAST) ? REG_LOAD : REG_INCR;
    end
  end

  always_comb begin
    w_secs_ctrl = REG_NONE;
    if (load) begin
      w_secs_ctrl = REG_LOAD;
    end else if (w_second && (w_secs != '0)) begin
      w_secs_ctrl = REG_DECR;
    end
  end

  bomb_register #(.W(PRESC_W)) u_prescaler (
    .clk          (clk),
    .async_nreset (async_nreset),
    .i_ctrl       (w_presc_ctrl),
    .i_value      ('0),
    .o_value      (w_presc)
  );

  bomb_register #(.W(SEC_W)) u_seconds (
    .clk          (clk),
    .async_nreset (async_nreset),
    .i_ctrl       (w_secs_ctrl),
    .i_value      (load_value),
    .o_value      (w_secs)
  );

`ifdef BOMB_TIMER_WARN_BEEP_EN
  assign beep = (w_run && (w_secs <= SEC_W'(WARN_SECS))) ? w_half : w_second;
`else
  assign beep = w_second;
`endif

  assign busy        = r_busy;
  assign expired     = r_expired;
  assign remaining   = w_secs;
  assign half_second = w_half;
  assign second      = w_second;

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Bench for bomb_countdown_timer: directed scenarios plus a random command
// stream checked against a run-cycle-counting reference model.
module tb_bomb_countdown_timer;

  localparam int CLK_HZ    = 10;
  localparam int PRESC_W   = 8;
  localparam int SEC_W     = 8;
  localparam int WARN_SECS = 2;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_EXP    = 3;

  logic             clk = 1'b0;
  logic             async_nreset = 1'b0;
  logic             load = 1'b0;
  logic [SEC_W-1:0] load_value = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             busy;
  logic [SEC_W-1:0] remaining;
  logic             half_second;
  logic             second;
  logic             expired;
  logic             beep;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: state, seconds left, and RUN cycles elapsed since the last load.
  int m_state = M_IDLE;
  int m_rem   = 0;
  int m_run   = 0;

  bomb_countdown_timer #(
    .CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W), .SEC_W(SEC_W), .WARN_SECS(WARN_SECS)
  ) dut (
    .clk(clk), .async_nreset(async_nreset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .busy(busy), .remaining(remaining),
    .half_second(half_second), .second(second), .expired(expired), .beep(beep)
  );

  always #5 clk = ~clk;

  function automatic bit exp_second();
    return (m_state == M_RUN) && ((m_run % CLK_HZ) == CLK_HZ - 1);
  endfunction

  function automatic bit exp_half();
    return (m_state == M_RUN) && (((m_run + 1) % (CLK_HZ / 2)) == 0);
  endfunction

  function automatic bit exp_beep();
`ifdef BOMB_TIMER_WARN_BEEP_EN
    return (m_state == M_RUN && m_rem <= WARN_SECS) ? exp_half() : exp_second();
`else
    return exp_second();
`endif
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_rem   = 0;
    m_run   = 0;
  endtask

  task automatic model_edge(input bit l, input int lv, input bit s, input bit p);
    bit sec;
    int old_rem;
    int old_state;
    sec       = exp_second();
    old_rem   = m_rem;
    old_state = m_state;
    if (l) begin
      m_rem   = lv;
      m_run   = 0;
      m_state = M_IDLE;
    end else begin
      if (old_state == M_RUN) begin
        m_run++;
        if (sec && m_rem > 0) m_rem--;
      end
      if (s && (old_state == M_IDLE || old_state == M_PAUSED)) begin
        m_state = (old_rem != 0) ? M_RUN : M_EXP;
      end else if (old_state == M_RUN) begin
        if (sec && old_rem == 1) m_state = M_EXP;
        else if (p) m_state = M_PAUSED;
      end
    end
  endtask

  // Apply one cycle of commands; returns #1 after the sampling edge.
  task automatic drive(input bit l, input int lv, input bit s, input bit p);
    load       = l;
    load_value = SEC_W'(lv);
    start      = s;
    pause      = p;
    @(posedge clk);
    model_edge(l, lv, s, p);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    async_nreset = 1'b0;
    #12;
    n_checks++;
    if ({busy, expired, half_second, second, beep, remaining} !== '0)
      $display("FAIL reset_outputs: got busy=%0b exp=%0b half=%0b sec=%0b beep=%0b rem=%0d required all 0",
               busy, expired, half_second, second, beep, remaining);
    else n_pass++;
    @(negedge clk);
    async_nreset = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      drive(0, 0, 0, 0);
      n_checks++;
      if ({busy, expired, half_second, second, beep, remaining} !== '0)
        $display("FAIL idle_quiet cycle %0d: got busy=%0b exp=%0b half=%0b sec=%0b beep=%0b rem=%0d required all 0",
                 i, busy, expired, half_second, second, beep, remaining);
      else n_pass++;
    end
  endtask

  task automatic test_full_countdown();
    bit e_half, e_sec, e_exp, e_busy;
    int e_rem;
    drive(1, 3, 0, 0);
    n_checks++;
    if (remaining !== 8'd3 || busy !== 1'b0)
      $display("FAIL load3: got rem=%0d busy=%0b required rem=3 busy=0", remaining, busy);
    else n_pass++;
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 40; i++) begin
      e_half = (i % 5 == 0) && (i <= 30);
      e_sec  = (i % 10 == 0) && (i <= 30);
      e_rem  = (i <= 30) ? 3 - (i - 1) / 10 : 0;
      e_exp  = (i >= 31);
      e_busy = (i <= 30);
      n_checks++;
      if (half_second !== e_half || second !== e_sec)
        $display("FAIL countdown_strobes cycle %0d: got half=%0b sec=%0b required half=%0b sec=%0b",
                 i, half_second, second, e_half, e_sec);
      else n_pass++;
      n_checks++;
      if (remaining !== SEC_W'(e_rem) || expired !== e_exp || busy !== e_busy)
        $display("FAIL countdown_state cycle %0d: got rem=%0d exp=%0b busy=%0b required rem=%0d exp=%0b busy=%0b",
                 i, remaining, expired, busy, e_rem, e_exp, e_busy);
      else n_pass++;
      n_checks++;
      if (beep !== exp_beep())
        $display("FAIL countdown_beep cycle %0d: got %0b required %0b", i, beep, exp_beep());
      else n_pass++;
      drive(0, 0, 0, 0);
    end
    drive(0, 0, 1, 0);
    n_checks++;
    if (expired !== 1'b1 || busy !== 1'b0)
      $display("FAIL start_in_expired: got exp=%0b busy=%0b required exp=1 busy=0", expired, busy);
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    int run_cnt;
    int first_sec;
    int second_sec;
    int guard;
    drive(1, 2, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      n_checks++;
      if (second !== 1'b0 || busy !== 1'b1)
        $display("FAIL pre_pause cycle %0d: got sec=%0b busy=%0b required sec=0 busy=1", i, second, busy);
      else n_pass++;
      if (i < 7) drive(0, 0, 0, 0);
      else drive(0, 0, 0, 1);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (busy !== 1'b0 || half_second !== 1'b0 || second !== 1'b0 || remaining !== 8'd2)
        $display("FAIL paused_hold cycle %0d: got busy=%0b half=%0b sec=%0b rem=%0d required 0/0/0/2",
                 i, busy, half_second, second, remaining);
      else n_pass++;
      drive(0, 0, 0, 0);
    end
    drive(0, 0, 1, 0);
    run_cnt    = 7;
    first_sec  = -1;
    second_sec = -1;
    guard      = 0;
    while (busy === 1'b1 && guard < 100) begin
      run_cnt++;
      if (second === 1'b1) begin
        if (first_sec < 0) first_sec = run_cnt;
        else second_sec = run_cnt;
      end
      drive(0, 0, 0, 0);
      guard++;
    end
    n_checks++;
    if (first_sec !== 10 || second_sec !== 20)
      $display("FAIL pause_resume_seconds: got run cycles %0d,%0d required 10,20", first_sec, second_sec);
    else n_pass++;
    n_checks++;
    if (run_cnt !== 20 || expired !== 1'b1)
      $display("FAIL pause_resume_total: got run=%0d exp=%0b required run=20 exp=1", run_cnt, expired);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1, 3, 0, 0);
    drive(0, 0, 1, 0);
    idle(9);
    n_checks++;
    if (second !== 1'b1)
      $display("FAIL load_vs_second_strobe: got sec=%0b required 1", second);
    else n_pass++;
    drive(1, 5, 0, 0);
    n_checks++;
    if (remaining !== 8'd5 || busy !== 1'b0 || expired !== 1'b0)
      $display("FAIL load_vs_second: got rem=%0d busy=%0b exp=%0b required rem=5 busy=0 exp=0",
               remaining, busy, expired);
    else n_pass++;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    n_checks++;
    if (expired !== 1'b1 || busy !== 1'b0)
      $display("FAIL start_at_zero: got exp=%0b busy=%0b required exp=1 busy=0", expired, busy);
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (half_second !== 1'b0 || second !== 1'b0 || remaining !== 8'd0)
        $display("FAIL zero_no_strobes cycle %0d: got half=%0b sec=%0b rem=%0d required 0/0/0",
                 i, half_second, second, remaining);
      else n_pass++;
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_priority();
    drive(1, 4, 0, 0);
    drive(0, 0, 1, 0);
    idle(3);
    drive(1, 7, 1, 1);
    n_checks++;
    if (remaining !== 8'd7 || busy !== 1'b0 || expired !== 1'b0)
      $display("FAIL prio_load_wins: got rem=%0d busy=%0b exp=%0b required rem=7 busy=0 exp=0",
               remaining, busy, expired);
    else n_pass++;
    drive(0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 1);
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL prio_pause: got busy=%0b required 0", busy);
    else n_pass++;
    drive(0, 0, 1, 1);
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL prio_start_over_pause: got busy=%0b required 1", busy);
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    drive(1, 3, 0, 0);
    drive(0, 0, 1, 0);
    idle(12);
    #2;
    async_nreset = 1'b0;
    #1;
    n_checks++;
    if ({busy, expired, half_second, second, remaining} !== '0)
      $display("FAIL async_reset_midcount: got busy=%0b exp=%0b half=%0b sec=%0b rem=%0d required all 0",
               busy, expired, half_second, second, remaining);
    else n_pass++;
    @(negedge clk);
    async_nreset = 1'b1;
    model_reset();
    drive(0, 0, 1, 0);
    n_checks++;
    if (expired !== 1'b1 || busy !== 1'b0)
      $display("FAIL start_after_reset: got exp=%0b busy=%0b required exp=1 busy=0", expired, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    bit l, s, p;
    int lv;
    for (int i = 0; i < 3000; i++) begin
      l  = ($urandom % 40) == 0;
      lv = $urandom_range(0, 4);
      s  = ($urandom % 8) == 0;
      p  = ($urandom % 10) == 0;
      drive(l, lv, s, p);
      n_checks++;
      if (remaining !== SEC_W'(m_rem) || busy !== (m_state == M_RUN) || expired !== (m_state == M_EXP))
        $display("FAIL random_state step %0d: got rem=%0d busy=%0b exp=%0b required rem=%0d busy=%0b exp=%0b",
                 i, remaining, busy, expired, m_rem, m_state == M_RUN, m_state == M_EXP);
      else n_pass++;
      n_checks++;
      if (half_second !== exp_half() || second !== exp_second() || beep !== exp_beep())
        $display("FAIL random_strobes step %0d: got half=%0b sec=%0b beep=%0b required half=%0b sec=%0b beep=%0b",
                 i, half_second, second, beep, exp_half(), exp_second(), exp_beep());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_countdown();
    test_pause_resume();
    test_simultaneous();
    test_priority();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
